// File: rtl/toggle_deserializer_if.sv
// ----------------------------------------------------------------------------
// toggle_deserializer_if
// Word-level valid/ready bus between the toggle deserializer and its consumer.
//
//   data_out   : decoded word, MSB = first bit received on the line
//   data_valid : data_out holds an unconsumed word
//   data_ready : consumer accepts the word when data_valid & data_ready
//
// Modports:
//   master : producer side (drives data_out/data_valid, samples data_ready)
//   slave  : consumer side (samples data_out/data_valid, drives data_ready)
// ----------------------------------------------------------------------------
interface toggle_deserializer_if #(
    parameter int unsigned WIDTH = 8
);

    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );

endinterface : toggle_deserializer_if

// File: rtl/toggle_deserializer.sv
// ----------------------------------------------------------------------------
// toggle_deserializer
// Receive side of the toggle (T-type) line code: a line transition is a '1',
// a held level is a '0'. Bits are recovered as current ^ previous line level,
// shifted MSB-first, and aligned by hunting for SYNC_WORD. Once locked, every
// WIDTH bits form a word that is offered on a valid/ready bus through a
// single holding register. A word that completes while the holding register
// is still full is dropped and flagged on the sticky overflow output.
//
// Ports:
//   clk        : system clock, all state updates on the rising edge
//   rst_n      : synchronous reset, active-low
//   i_line_in  : sampled line level, qualified by i_bit_en
//   i_bit_en   : one-cycle strobe, i_line_in holds a new bit period
//   i_resync   : one-cycle pulse, drop alignment and return to hunting
//   io_bus     : word output (data_out / data_valid / data_ready)
//   o_locked   : 1 while word-aligned
//   o_overflow : sticky, a completed word was dropped (cleared by reset only)
// ----------------------------------------------------------------------------
module toggle_deserializer #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hA5)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_line_in,
    input  logic                  i_bit_en,
    input  logic                  i_resync,
    toggle_deserializer_if.master io_bus,
    output logic                  o_locked,
    output logic                  o_overflow
);

    // Bit counter only needs to reach WIDTH-1 before wrapping.
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic               r_prev_level;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_data_valid;
    logic               r_locked;
    logic               r_overflow;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t             w_state_next;
    logic               w_bit;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_shift_d;
    logic [CNT_W-1:0]   w_bit_cnt_d;
    logic               w_word_done;
    logic               w_reg_free;
    logic               w_load;
    logic               w_drop;
    logic               w_drain;

    // Toggle decode and MSB-first shift candidate.
    assign w_bit        = i_line_in ^ r_prev_level;
    assign w_shift_next = {r_shift[WIDTH-2:0], w_bit};

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic (resync overrides any lock attempt)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (i_resync) begin
            w_state_next = ST_HUNT;
        end else if (i_bit_en) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_shift_next == SYNC_WORD) begin
                        w_state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    w_state_next = ST_LOCKED;
                end
                default: begin
                    w_state_next = ST_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: per-state datapath controls
    // A strobe in the resync cycle is discarded from the shifter; the
    // previous-level register is handled separately and still updates.
    // ------------------------------------------------------------------
    always_comb begin
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_word_done = 1'b0;
        if (i_resync) begin
            w_shift_d   = '0;
            w_bit_cnt_d = '0;
        end else if (i_bit_en) begin
            w_shift_d = w_shift_next;
            case (r_state)
                ST_HUNT: begin
                    // Alignment restarts from zero when the sync word lands.
                    w_bit_cnt_d = '0;
                end
                ST_LOCKED: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_d = '0;
                        w_word_done = 1'b1;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_bit_cnt_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decode path registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_level <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_locked     <= 1'b0;
        end else begin
            if (i_bit_en) begin
                r_prev_level <= i_line_in;
            end
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_locked  <= (w_state_next == ST_LOCKED);
        end
    end

    // ------------------------------------------------------------------
    // Holding register handshake
    // The register is free if empty or being consumed in this same cycle,
    // which lets back-to-back words stream without a bubble.
    // ------------------------------------------------------------------
    assign w_reg_free = ~r_data_valid | io_bus.data_ready;
    assign w_load     = w_word_done & w_reg_free;
    assign w_drop     = w_word_done & ~w_reg_free;
    assign w_drain    = ~w_word_done & r_data_valid & io_bus.data_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_out   <= w_shift_next;
                r_data_valid <= 1'b1;
            end else if (w_drain) begin
                r_data_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_bus.data_out   = r_data_out;
    assign io_bus.data_valid = r_data_valid;
    assign o_locked          = r_locked;
    assign o_overflow        = r_overflow;

    // ------------------------------------------------------------------
    // Design invariants
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    logic r_chk_armed;

    always_ff @(posedge clk) begin
        r_chk_armed <= rst_n;
    end

    // A held word must not change under backpressure.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n || !r_chk_armed)
        (r_data_valid && !io_bus.data_ready) |=> (r_data_out == $past(r_data_out)));

    // Overflow is sticky until reset.
    a_ovf_sticky: assert property (@(posedge clk) disable iff (!rst_n || !r_chk_armed)
        r_overflow |=> r_overflow);

    // The locked flag always mirrors the state register.
    a_lock_state: assert property (@(posedge clk) disable iff (!r_chk_armed)
        r_locked == (r_state == ST_LOCKED));
`endif

endmodule : toggle_deserializer

// File: tb/tb_toggle_deserializer.sv
// ----------------------------------------------------------------------------
// tb_toggle_deserializer
// Self-checking bench: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the toggle decoder,
// sync hunt and one-word holding register.
// ----------------------------------------------------------------------------
module tb_toggle_deserializer;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] SYNC = 8'hA5;
    localparam int unsigned MASK = (1 << WIDTH) - 1;

    logic clk;
    logic rst_n;
    logic line_in;
    logic bit_en;
    logic resync;
    logic locked;
    logic overflow;

    toggle_deserializer_if #(.WIDTH(WIDTH)) bus ();

    toggle_deserializer #(
        .WIDTH     (WIDTH),
        .SYNC_WORD (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_line_in  (line_in),
        .i_bit_en   (bit_en),
        .i_resync   (resync),
        .io_bus     (bus),
        .o_locked   (locked),
        .o_overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_prev;
    bit          m_locked;
    int unsigned m_win;
    bit          m_q[$];
    bit          m_valid;
    int unsigned m_out;
    bit          m_ovf;
    bit          tb_level;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: one call per clock edge with that edge's inputs.
    task automatic model_step(input bit ln, input bit en, input bit rs, input bit rdy, input bit rst);
        bit          b;
        bit          done;
        int unsigned word;
        if (!rst) begin
            m_prev = 0; m_locked = 0; m_win = 0; m_q.delete();
            m_valid = 0; m_out = 0; m_ovf = 0;
            return;
        end
        done = 0;
        word = 0;
        b    = 0;
        if (en) begin
            b = ln ^ m_prev;
            m_prev = ln;
        end
        if (rs) begin
            m_locked = 0;
            m_win = 0;
            m_q.delete();
        end else if (en) begin
            m_win = ((m_win << 1) | int'(b)) & MASK;
            if (!m_locked) begin
                if (m_win == int'(SYNC)) begin
                    m_locked = 1;
                    m_q.delete();
                end
            end else begin
                m_q.push_back(b);
                if (m_q.size() == WIDTH) begin
                    foreach (m_q[i]) word = (word << 1) | int'(m_q[i]);
                    m_q.delete();
                    done = 1;
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_out = word;
                m_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    // Drive one clock cycle, advance the model, compare all outputs.
    task automatic cyc(input bit ln, input bit en, input bit rs, input bit rdy, input bit rst);
        line_in        = ln;
        bit_en         = en;
        resync         = rs;
        bus.data_ready = rdy;
        rst_n          = rst;
        @(posedge clk);
        model_step(ln, en, rs, rdy, rst);
        if (!rst)    tb_level = 0;
        else if (en) tb_level = ln;
        #1;
        check_eq("data_valid", 32'(bus.data_valid), 32'(m_valid));
        check_eq("data_out",   32'(bus.data_out),   32'(m_out));
        check_eq("locked",     32'(locked),         32'(m_locked));
        check_eq("overflow",   32'(overflow),       32'(m_ovf));
    endtask

    task automatic idle(input bit rdy);
        cyc(tb_level, 0, 0, rdy, 1);
    endtask

    // Strobe a decoded word MSB-first at full rate; rdy_last applies to the final strobe.
    task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy, input bit rdy_last);
        logic [WIDTH-1:0] v;
        v = w;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cyc(tb_level ^ v[i], 1, 0, (i == 0) ? rdy_last : rdy, 1);
        end
    endtask

    initial begin
        tb_level = 0;

        // Reset state
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check_eq("rst_valid", 32'(bus.data_valid), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);

        // Lock: levels 1,1,0,0,0,1,1,0
        send_word(8'hA5, 1, 1);
        check_eq("lock_locked", 32'(locked), 32'd1);
        check_eq("lock_valid", 32'(bus.data_valid), 32'd0);

        // Word decode, valid for exactly one cycle
        send_word(8'h3C, 1, 1);
        check_eq("dec_data", 32'(bus.data_out), 32'h3C);
        check_eq("dec_valid", 32'(bus.data_valid), 32'd1);
        idle(1);
        check_eq("dec_valid_pulse", 32'(bus.data_valid), 32'd0);

        // Backpressure / overflow
        send_word(8'h3C, 0, 0);
        send_word(8'hFF, 0, 0);
        check_eq("bp_data", 32'(bus.data_out), 32'h3C);
        check_eq("bp_ovf", 32'(overflow), 32'd1);
        idle(1);
        check_eq("bp_drain_valid", 32'(bus.data_valid), 32'd0);
        check_eq("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous accept and completion
        cyc(0, 0, 0, 0, 0);
        send_word(8'hA5, 0, 0);
        send_word(8'h3C, 0, 0);
        send_word(8'h81, 0, 1);
        check_eq("sim_data", 32'(bus.data_out), 32'h81);
        check_eq("sim_valid", 32'(bus.data_valid), 32'd1);
        check_eq("sim_ovf", 32'(overflow), 32'd0);
        idle(1);

        // Resync mid-word with a coincident strobe
        for (int i = 0; i < 4; i++) cyc(tb_level ^ 1'(i < 2), 1, 0, 1, 1);
        cyc(tb_level ^ 1'b1, 1, 1, 1, 1);
        check_eq("rs_locked", 32'(locked), 32'd0);
        for (int i = 0; i < 6; i++) idle(1);
        check_eq("rs_no_word", 32'(bus.data_valid), 32'd0);
        send_word(8'hA5, 1, 1);
        check_eq("rs_relock", 32'(locked), 32'd1);
        send_word(8'h5A, 1, 1);
        check_eq("rs_data", 32'(bus.data_out), 32'h5A);
        check_eq("rs_valid", 32'(bus.data_valid), 32'd1);

        // Reset mid-operation with a held word and overflow set
        send_word(8'h11, 0, 0);
        send_word(8'h22, 0, 0);
        check_eq("pre_rst_ovf", 32'(overflow), 32'd1);
        cyc(tb_level, 0, 0, 0, 0);
        check_eq("mid_rst_valid", 32'(bus.data_valid), 32'd0);
        check_eq("mid_rst_data", 32'(bus.data_out), 32'd0);
        check_eq("mid_rst_locked", 32'(locked), 32'd0);
        check_eq("mid_rst_ovf", 32'(overflow), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 6000; n++) begin
            bit ln, en, rs, rdy, rst;
            ln  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) < 7);
            rs  = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 1499) != 0);
            cyc(ln, en, rs, rdy, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_toggle_deserializer

// File: doc/toggle_deserializer.md
Name: toggle_deserializer

Overview:
- Receive-side counterpart to the team's toggle (T-type) line encoding. A transmitter toggles the line level for a '1' and holds it for a '0'.
- Recovers each bit as the XOR of the current and previous line levels and hunts for a sync word.
- Once locked, deserializes WIDTH-bit words and presents them on a valid/ready output with a one-word holding register.
- Sits between the serial line sampler and the word-level consumer.

Parameters:
- WIDTH, 8, decoded word width in bits (≥2).
- SYNC_WORD, 8'hA5, WIDTH-bit pattern that establishes word alignment.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- line_in  input  1  sampled line level, qualified by bit_en.
- bit_en  input  1  one-cycle strobe: line_in holds a new bit period.
- resync  input  1  one-cycle pulse: drop alignment and return to hunting.
- data_out  output  WIDTH  decoded word, MSB = first bit received.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts word when data_valid & data_ready.
- locked  output  1  1 while word-aligned (LOCKED state).
- overflow  output  1  sticky: a completed word was dropped because the holding register was full.

Behaviour:
- Reset: the following registers clear on the rising edge with rst_n=0:
  - prev_level=0, shift=0, bit_cnt=0, state=HUNT.
  - data_out=0, data_valid=0, locked=0, overflow=0.
- Bit recovery:
  - On bit_en=1: b = line_in ^ prev_level; prev_level <= line_in.
  - bit_en=0 changes nothing in the decode path.
- Shift: shift_next = {shift[WIDTH-2:0], b}, i.e. MSB-first.
- HUNT:
  - Each strobe loads shift_next.
  - If shift_next == SYNC_WORD: go to LOCKED, bit_cnt <= 0, locked=1 from the next cycle.
  - The sync word is never output.
- LOCKED:
  - Each strobe loads shift_next and increments bit_cnt.
  - On the WIDTH-th bit, bit_cnt wraps to 0 and the word completes, with word = shift_next.
  - A SYNC_WORD pattern while LOCKED is ordinary data.
- Output handshake:
  - When a word completes and the register is free (data_valid=0, or data_ready=1 in the same cycle): data_out <= word, data_valid <= 1 next cycle. Latency is one clock after the final strobe.
  - When a word completes and the register is full (data_valid=1 and data_ready=0): word dropped, data_out unchanged, overflow <= 1.
  - Transfer with no new word: data_valid <= 0; data_out holds its last value.
  - data_out is stable while data_valid=1 and data_ready=0.
- resync=1 (has priority over everything except reset):
  - state <= HUNT, locked <= 0, shift <= 0, bit_cnt <= 0.
  - Any bit strobed in the same cycle is discarded from shift, but prev_level still updates.
  - Holding register, data_valid and overflow are unaffected.
- overflow clears only on reset.
- bit_en may be asserted every cycle (full rate) with no loss.
- Reset mid-word discards the partial word and any held word.

Test Plan:
- Lock: after reset, strobe line levels 1,1,0,0,0,1,1,0 (decoded A5) → locked=1 the cycle after the 8th strobe; data_valid stays 0.
- Word decode: locked, prev_level=0; strobe levels 0,0,1,0,1,0,0,0 with data_ready=1 → data_out=8'h3C, data_valid=1 for exactly one cycle, one clock after the 8th strobe.
- Backpressure/overflow: data_ready=0; decode words 8'h3C then 8'hFF → data_out stays 8'h3C and overflow=1; raising data_ready clears data_valid, and overflow stays 1.
- Simultaneous accept: data_valid=1 with 8'h3C; the cycle data_ready=1 coincides with 8'h81 completing → next cycle data_out=8'h81, data_valid=1, overflow=0.
- Resync: mid-word (4 bits in), pulse resync together with a strobe → locked=0, no word output; re-sending A5 relocks, and the next 8 bits decode correctly.
- Reset mid-operation: rst_n=0 for one cycle while data_valid=1 and overflow=1 → all outputs 0 and state HUNT the next cycle.
